// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_t    : operation encoding presented on the request bus (6/7 reserved)
//   state_t : control FSM states of hilo_muldiv_unit
//   div_latency() / DIV_LATENCY : accept-to-result edges for DIV/DIVU
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MTHI  = 3'd0,
    OP_MTLO  = 3'd1,
    OP_MULT  = 3'd2,
    OP_MULTU = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX
  } state_t;

  // One prep cycle, one cycle per quotient bit, one sign-fix cycle.
  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

  localparam int DEFAULT_WIDTH = 32;
  localparam int DIV_LATENCY   = div_latency(DEFAULT_WIDTH);

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bus between the execute stage and the HI/LO unit.
//   master : requester (drives start/op/in_a/in_b, observes busy/done/hi/lo)
//   slave  : hilo_muldiv_unit
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, in_a, in_b, input busy, done, hi, lo);
  modport slave  (input start, op, in_a, in_b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   start               : load dividend/divisor and begin WIDTH iterations
//   dividend, divisor   : unsigned magnitudes
//   done                : high during the final iteration cycle; quotient and
//                         remainder are valid from the following cycle on
//   quotient, remainder : results (held until the next start)
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; the remainder stays below the divisor, so WIDTH+1 bits
  // always suffice for the shifted value.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    diff    = shifted[WIDTH-1:0] - dvs_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: only control (active/cnt) is reset; the datapath registers are
  // fully reloaded on start, so resetting them would add nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (active) begin
      rem_q <= fits ? diff : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) active <= 1'b0;
    end
  end

  assign done      = active && (cnt == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset : clock, synchronous active-high reset (aborts any operation)
//   bus.start/op/in_a/in_b : request, accepted when start=1 and busy=0
//   bus.busy   : a MULT/DIV is in flight
//   bus.done   : one-cycle pulse after HI/LO take a MULT/DIV result
//   bus.hi/lo  : architectural HI and LO registers
// MULT/MULTU write {hi,lo} MUL_LATENCY edges after accept; DIV/DIVU write
// lo=quotient, hi=remainder WIDTH+2 edges after accept.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam int             MCW      = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_LATENCY - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic [MCW-1:0]     mul_cnt;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_full, prod_q;
  logic [WIDTH-1:0]   a_q, b_q, abs_a, abs_b;
  logic               div_signed, q_neg, r_neg;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo, div_rem, quo_fix, rem_fix;

  // Sign- or zero-extending both operands to 2*WIDTH makes a plain unsigned
  // multiply yield the correct two's-complement product in either mode.
  always_comb begin
    ext_a = (bus.op == OP_MULT) ? {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a}
                                : {{WIDTH{1'b0}}, bus.in_a};
    ext_b = (bus.op == OP_MULT) ? {{WIDTH{bus.in_b[WIDTH-1]}}, bus.in_b}
                                : {{WIDTH{1'b0}}, bus.in_b};
    prod_full = ext_a * ext_b;
  end

  // Magnitudes for the unsigned core. The most-negative value maps onto its
  // own bit pattern, which is the correct unsigned magnitude; with a divisor
  // of -1 this makes the overflow case fall out as lo=most-negative, hi=0.
  always_comb begin
    abs_a   = (div_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b   = (div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    quo_fix = q_neg ? -div_quo : div_quo;
    rem_fix = r_neg ? -div_rem : div_rem;
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (state == ST_DIV_PREP),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULT || bus.op == OP_MULTU)    state_nxt = ST_MUL;
          else if (bus.op == OP_DIV || bus.op == OP_DIVU) state_nxt = ST_DIV_PREP;
        end
      end
      ST_MUL:      if (mul_cnt == MUL_LAST) state_nxt = ST_IDLE;
      ST_DIV_PREP: state_nxt = ST_DIV_ITER;
      ST_DIV_ITER: if (div_done) state_nxt = ST_DIV_FIX;
      ST_DIV_FIX:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Requests are only looked at in IDLE, so anything presented while busy,
  // including MTHI/MTLO, is dropped; reserved opcodes fall to the default.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      mul_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.in_a;
              OP_MTLO: lo_q <= bus.in_a;
              OP_MULT, OP_MULTU: begin
                prod_q  <= prod_full;
                mul_cnt <= '0;
              end
              OP_DIV, OP_DIVU: begin
                a_q        <= bus.in_a;
                b_q        <= bus.in_b;
                div_signed <= (bus.op == OP_DIV);
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_cnt == MUL_LAST) begin
            {hi_q, lo_q} <= prod_q;
            done_q       <= 1'b1;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        ST_DIV_PREP: begin
          // Quotient is negative when signs differ; remainder follows dividend.
          q_neg <= div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          r_neg <= div_signed && a_q[WIDTH-1];
        end
        ST_DIV_FIX: begin
          if (b_q == '0) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit. Two instances (MUL_LATENCY 1 and
// 3) share one request stream; an arithmetic model predicts busy/done/hi/lo
// for each and is compared every cycle, and directed vectors pin literals.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] in_a  = '0;
  logic [31:0] in_b  = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          cmp_en   = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus1 ();
  hilo_muldiv_unit_if #(.WIDTH(32)) bus3 ();

  assign bus1.start = start;  assign bus3.start = start;
  assign bus1.op    = op;     assign bus3.op    = op;
  assign bus1.in_a  = in_a;   assign bus3.in_a  = in_a;
  assign bus1.in_b  = in_b;   assign bus3.in_b  = in_b;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  hilo_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result {hi,lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint p;
    int     q, r;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: cycles-left countdown per instance; result lands when it hits 0.
  localparam int LAT [2] = '{1, 3};
  logic [31:0] m_hi [2], m_lo [2], p_hi [2], p_lo [2];
  int          m_left [2];
  bit          m_done [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_hi[i]   <= '0;
        m_lo[i]   <= '0;
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_hi[i]   <= p_hi[i];
            m_lo[i]   <= p_lo[i];
            m_done[i] <= 1'b1;
          end
        end else if (start) begin
          case (op)
            OP_MTHI: m_hi[i] <= in_a;
            OP_MTLO: m_lo[i] <= in_a;
            OP_MULT, OP_MULTU: begin
              {p_hi[i], p_lo[i]} <= model_result(op, in_a, in_b);
              m_left[i]          <= LAT[i];
            end
            OP_DIV, OP_DIVU: begin
              {p_hi[i], p_lo[i]} <= model_result(op, in_a, in_b);
              m_left[i]          <= 34;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("lat1_busy", bus1.busy, m_left[0] > 0);
      check("lat1_done", bus1.done, m_done[0]);
      check("lat1_hi",   bus1.hi,   m_hi[0]);
      check("lat1_lo",   bus1.lo,   m_lo[0]);
      check("lat3_busy", bus3.busy, m_left[1] > 0);
      check("lat3_done", bus3.done, m_done[1]);
      check("lat3_hi",   bus3.hi,   m_hi[1]);
      check("lat3_lo",   bus3.lo,   m_lo[1]);
    end
  end

  int b1, b3, d1, d3;

  // Pulse one request, scramble inputs afterwards, then observe 40 cycles,
  // counting busy/done cycles. poke_at>=0 injects an MTHI 0x1234 at that cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
    b1 = 0; b3 = 0; d1 = 0; d3 = 0;
    @(negedge clk);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clk);
    start = 1'b0; in_a = ~a; in_b = ~b;
    for (int i = 0; i < 40; i++) begin
      if (bus1.busy) b1++;
      if (bus3.busy) b3++;
      if (bus1.done) d1++;
      if (bus3.done) d3++;
      if (i == poke_at) begin
        start = 1'b1; op = OP_MTHI; in_a = 32'h0000_1234;
      end else if (i == poke_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    check("reset_hi",   bus3.hi,   32'd0);
    check("reset_lo",   bus3.lo,   32'd0);
    check("reset_busy", bus3.busy, 1'b0);
    check("reset_done", bus3.done, 1'b0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_hi",        bus1.hi, 32'hFFFF_FFFE);
    check("multu_lo",        bus1.lo, 32'h0000_0001);
    check("multu_busy_lat1", b1, 1);
    check("multu_done_lat1", d1, 1);
    check("multu_busy_lat3", b3, 3);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1);
    check("mult_hi",        bus3.hi, 32'hFFFF_FFFF);
    check("mult_lo",        bus3.lo, 32'hFFFF_FFEB);
    check("mult_busy_lat3", b3, 3);
    check("mult_done_lat3", d3, 1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_neg_lo",   bus3.lo, 32'hFFFF_FFFD);
    check("div_neg_hi",   bus3.hi, 32'hFFFF_FFFF);
    check("div_neg_busy", b3, 34);
    check("div_neg_done", d3, 1);

    run_op(OP_DIVU, 32'd7, 32'd2, 5);
    check("divu_mthi_ignored_lo", bus3.lo, 32'd3);
    check("divu_mthi_ignored_hi", bus3.hi, 32'd1);

    run_op(OP_DIVU, 32'd100, 32'd0, -1);
    check("divu_zero_hi",   bus3.hi, 32'h0000_0064);
    check("divu_zero_lo",   bus3.lo, 32'hFFFF_FFFF);
    check("divu_zero_busy", b3, 34);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo", bus3.lo, 32'h8000_0000);
    check("div_ovf_hi", bus3.hi, 32'd0);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1);
    check("div_negdvs_lo", bus3.lo, 32'hFFFF_FFFD);
    check("div_negdvs_hi", bus3.hi, 32'd1);

    run_op(OP_MTLO, 32'h0000_ABCD, 32'd0, -1);
    check("mtlo_lo",   bus3.lo, 32'h0000_ABCD);
    check("mtlo_hi",   bus3.hi, 32'd1);
    check("mtlo_busy", b3, 0);
    check("mtlo_done", d3, 0);

    run_op(OP_MTHI, 32'h0000_5555, 32'd0, -1);
    check("mthi_hi", bus3.hi, 32'h0000_5555);

    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1);
    check("reserved_busy", b3, 0);
    check("reserved_hi",   bus3.hi, 32'h0000_5555);
    check("reserved_lo",   bus3.lo, 32'h0000_ABCD);

    // Abort a DIV about ten cycles in.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; in_a = 32'd1000; in_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi",   bus3.hi,   32'd0);
    check("abort_lo",   bus3.lo,   32'd0);
    check("abort_busy", bus3.busy, 1'b0);
    d1 = 0; d3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.done) d1++;
      if (bus3.done) d3++;
      @(negedge clk);
    end
    check("abort_no_done_lat1", d1, 0);
    check("abort_no_done_lat3", d3, 0);

    run_op(OP_DIVU, 32'd9, 32'd3, -1);
    check("after_abort_lo", bus3.lo, 32'd3);
    check("after_abort_hi", bus3.hi, 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
